// File: rtl/via_bus_ctrl.sv
// -----------------------------------------------------------------------------
// via_bus_ctrl
//   Shares one 6522 VIA between two requesters: the CPU and the keyboard
//   scanner. A free-running 4-bit phase counter divides the 16 MHz clock
//   into 16-cycle slots and produces the 1 MHz VIA clock (8 low, 8 high).
//   At the last phase of every slot (PH==15) the pending requests are
//   arbitrated. The winner's access is presented to the VIA for the whole
//   next slot. Its ACK pulses at the first phase after that slot.
//
// Optional feature (macro VIA_ARB_FAIR_EN):
//   When defined, a small counter tracks how many consecutive arbitrations
//   the scanner has lost while requesting. After two losses the scanner
//   wins the next contested arbitration. When undefined, the CPU always
//   wins a contested arbitration.
//
// Ports:
//   i_clk                    16 MHz system clock, rising edge
//   i_rst                    asynchronous reset, active high
//   i_cpuReq/RnW/Rs/Wdata    CPU access request, held until o_cpuAck
//   o_cpuAck, o_cpuRdata     CPU completion pulse and read data
//   i_scnReq/RnW/Rs/Wdata    scanner access request, same protocol as CPU
//   o_scnAck, o_scnRdata     scanner completion pulse and read data
//   o_viaPhi2                1 MHz VIA clock
//   o_viaCs1                 VIA chip select
//   o_viaRnW                 VIA access direction (1 = read)
//   o_viaRs                  VIA register select
//   o_viaWdata, o_viaWen     write data and its drive enable
//   i_viaRdata               VIA read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module via_bus_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cpuReq,
  input  logic       i_cpuRnW,
  input  logic [3:0] i_cpuRs,
  input  logic [7:0] i_cpuWdata,
  output logic       o_cpuAck,
  output logic [7:0] o_cpuRdata,
  input  logic       i_scnReq,
  input  logic       i_scnRnW,
  input  logic [3:0] i_scnRs,
  input  logic [7:0] i_scnWdata,
  output logic       o_scnAck,
  output logic [7:0] o_scnRdata,
  output logic       o_viaPhi2,
  output logic       o_viaCs1,
  output logic       o_viaRnW,
  output logic [3:0] o_viaRs,
  output logic [7:0] o_viaWdata,
  output logic       o_viaWen,
  input  logic [7:0] i_viaRdata
);

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [3:0] r_ph;
  logic [3:0] w_phNext;
  logic       r_phi2;
  logic       r_ownerScn;
  logic       r_rnw;
  logic [3:0] r_rs;
  logic [7:0] r_wdata;
  logic [7:0] r_cpuRdata;
  logic [7:0] r_scnRdata;
  logic       r_cpuAck;
  logic       r_scnAck;
  logic       w_arb;
  logic       w_anyReq;
  logic       w_slotEnd;
  logic       w_grantScn;

  assign w_phNext  = r_ph + 4'd1;
  assign w_arb     = (r_ph == 4'd15);
  assign w_anyReq  = i_cpuReq | i_scnReq;
  assign w_slotEnd = w_arb && (r_state == SLOT);

`ifdef VIA_ARB_FAIR_EN
  // Consecutive scanner losses while it was requesting. Bit 1 set means
  // two losses have accumulated and the scanner takes the next contest.
  logic [1:0] r_starve;

  assign w_grantScn = i_scnReq & (~i_cpuReq | r_starve[1]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve <= 2'd0;
    end else if (w_arb && i_scnReq) begin
      if (w_grantScn) begin
        r_starve <= 2'd0;
      end else if (!r_starve[1]) begin
        r_starve <= r_starve + 2'd1;
      end
    end
  end
`else
  assign w_grantScn = i_scnReq & ~i_cpuReq;
`endif

  // Phase counter and the VIA clock. PHI2 is registered from the next
  // phase value so that it is high exactly while PH is 8..15.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph   <= 4'd0;
      r_phi2 <= 1'b0;
    end else begin
      r_ph   <= w_phNext;
      r_phi2 <= w_phNext[3];
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: decisions are taken only at the slot boundary. A request
  // still high at the boundary starts another slot with no idle gap.
  always_comb begin
    w_stateNext = r_state;
    if (w_arb) begin
      w_stateNext = w_anyReq ? SLOT : IDLE;
    end
  end

  // Grant latch. RS and write data keep their last values while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ownerScn <= 1'b0;
      r_rnw      <= 1'b1;
      r_rs       <= 4'd0;
      r_wdata    <= 8'd0;
    end else if (w_arb && w_anyReq) begin
      r_ownerScn <= w_grantScn;
      r_rnw      <= w_grantScn ? i_scnRnW   : i_cpuRnW;
      r_rs       <= w_grantScn ? i_scnRs    : i_cpuRs;
      r_wdata    <= w_grantScn ? i_scnWdata : i_cpuWdata;
    end
  end

  // Completion: read data is taken from the VIA on the last phase of a
  // read slot, and the owner's ACK fires in the following cycle. Only one
  // owner exists per slot, so the two ACKs can never overlap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpuAck   <= 1'b0;
      r_scnAck   <= 1'b0;
      r_cpuRdata <= 8'd0;
      r_scnRdata <= 8'd0;
    end else begin
      r_cpuAck <= w_slotEnd && !r_ownerScn;
      r_scnAck <= w_slotEnd &&  r_ownerScn;
      if (w_slotEnd && r_rnw) begin
        if (r_ownerScn) begin
          r_scnRdata <= i_viaRdata;
        end else begin
          r_cpuRdata <= i_viaRdata;
        end
      end
    end
  end

  // VIA strobes follow the state directly, so a reset drops them at once.
  // Write data is only driven during the high half of the VIA clock.
  always_comb begin
    o_viaCs1 = 1'b0;
    o_viaRnW = 1'b1;
    o_viaWen = 1'b0;
    if (r_state == SLOT) begin
      o_viaCs1 = 1'b1;
      o_viaRnW = r_rnw;
      o_viaWen = ~r_rnw & r_ph[3];
    end
  end

  assign o_viaPhi2  = r_phi2;
  assign o_viaRs    = r_rs;
  assign o_viaWdata = r_wdata;
  assign o_cpuAck   = r_cpuAck;
  assign o_scnAck   = r_scnAck;
  assign o_cpuRdata = r_cpuRdata;
  assign o_scnRdata = r_scnRdata;

endmodule

// File: doc/via_bus_ctrl.md
VIA_BUS_CTRL -- requirements
Module: via_bus_ctrl

Interface
REQ-001 CLK  in  1  system clock, 16 MHz; all state is updated on the rising edge.
REQ-002 RESET  in  1  asynchronous reset, active-high.
REQ-003 CPU_REQ  in  1  CPU requests one VIA register access; must be held until CPU_ACK.
REQ-004 CPU_RnW, CPU_RS[3:0], CPU_WDATA[7:0]  in  1/4/8  CPU access direction, register select and write data.
REQ-005 CPU_ACK  out  1  one-cycle completion pulse; CPU_RDATA[7:0] (out 8) is valid from this cycle until the next ACK.
REQ-006 SCN_REQ, SCN_RnW, SCN_RS[3:0], SCN_WDATA[7:0]  in  1/1/4/8  keyboard-scanner requester, same protocol as CPU.
REQ-007 SCN_ACK  out  1, SCN_RDATA[7:0]  out  8  scanner completion pulse and read data.
REQ-008 VIA_PHI2  out  1  1 MHz VIA clock.
REQ-009 VIA_CS1  out  1  VIA chip select.
REQ-010 VIA_RnW  out  1  VIA access direction.
REQ-011 VIA_RS[3:0]  out  4  VIA register select.
REQ-012 VIA_WDATA[7:0]  out  8  write data.
REQ-013 VIA_WEN  out  1  write-data drive enable.
REQ-014 VIA_RDATA[7:0]  in  8  VIA read data.

Function
REQ-015 A free-running 4-bit phase counter PH SHALL increment every CLK and wrap from 15 to 0.
REQ-016 VIA_PHI2 SHALL be 0 for PH 0..7 and 1 for PH 8..15, registered: 8 cycles low, 8 cycles high.
REQ-017 A slot is PH 0..15; arbitration SHALL occur only in the cycle where PH==15, sampling the REQ inputs in that cycle.
REQ-018 The FSM SHALL have two states, IDLE and SLOT: IDLE->SLOT at PH==15 if any REQ is high; SLOT->SLOT at PH==15 if any REQ is high; SLOT->IDLE at PH==15 otherwise.
REQ-019 The grant SHALL latch the winner's RnW, RS and WDATA at PH==15; VIA_CS1/VIA_RnW/VIA_RS SHALL be valid for the whole following slot (PH 0..15).
REQ-020 Priority: when both requesters are high at arbitration, CPU SHALL win unless REQ-034 applies.
REQ-021 Write slot: VIA_WEN=1 and VIA_WDATA driven for PH 8..15; VIA_WEN=0 otherwise.
REQ-022 Read slot: VIA_RDATA SHALL be captured at PH==15 into the winner's RDATA register; the other requester's RDATA SHALL be unchanged.
REQ-023 The winner's ACK SHALL pulse for exactly one cycle at PH==0 following its slot; worst-case latency is 32 cycles from REQ, best case 17 (REQ first seen at PH==15).
REQ-024 A REQ still high at the slot's final PH==15 SHALL be treated as a new request, giving back-to-back slots with no idle gap.
REQ-025 REQ dropped before ACK (protocol violation): the slot SHALL complete and ACK SHALL still pulse.
REQ-026 IDLE: VIA_CS1=0, VIA_WEN=0, VIA_RnW=1; VIA_RS SHALL hold its last value.
REQ-027 At most one ACK SHALL be high in any cycle.

Reset
REQ-028 RESET high SHALL asynchronously force PH=0, state=IDLE and VIA_PHI2=0.
REQ-029 RESET high SHALL force VIA_CS1=0, VIA_WEN=0, VIA_RnW=1, VIA_RS=0 and VIA_WDATA=0.
REQ-030 RESET high SHALL force CPU_ACK=0, SCN_ACK=0, CPU_RDATA=0 and SCN_RDATA=0.
REQ-031 RESET high SHALL clear the starvation counter.
REQ-032 Reset mid-slot SHALL abort the slot without ACK; the aborted requester SHALL be re-arbitrated normally after release.
REQ-033 After RESET falls, the first arbitration SHALL occur at the first PH==15, i.e. the 16th rising edge.

Configuration
REQ-034 With VIA_ARB_FAIR_EN defined, a 2-bit counter SHALL count consecutive arbitrations the scanner loses while SCN_REQ is high; at count 2 the scanner SHALL win the next contested arbitration; the counter SHALL clear on any scanner grant.
REQ-035 Without VIA_ARB_FAIR_EN, priority SHALL be strict CPU-first, no counter SHALL exist, and the scanner MAY starve.

Verification
REQ-036 Release reset, CPU read RS=4 with VIA_RDATA=0x5A -> CS1 in PH 0..15 of slot 2, CPU_ACK at cycle 32, CPU_RDATA=0x5A.
REQ-037 CPU write RS=3 data 0xFF -> VIA_WEN=1 only during PH 8..15, VIA_WDATA=0xFF, VIA_RnW=0, single CPU_ACK.
REQ-038 CPU and SCN both held high for 4 slots (fair build) -> grants CPU, CPU, SCN, CPU; strict build -> CPU x4 with no SCN_ACK.
REQ-039 SCN_REQ first raised at PH==15 -> granted in that cycle, SCN_ACK 17 cycles later.
REQ-040 RESET asserted at PH==10 of a write slot -> VIA_WEN/VIA_CS1 drop immediately, no ACK, PH restarts at 0.
REQ-041 CPU_REQ held for 3 slots -> 3 contiguous slots, CS1 never low between them, 3 ACK pulses 16 cycles apart.
